// File: rtl/key_pkg.sv
// Shared definitions for the keyboard action decoder: scan codes,
// repeat-timer state encoding and counter sizing.
package key_pkg;

    localparam int CODE_W = 9;
    localparam int KMAP_W = 1 << CODE_W;

    localparam logic [CODE_W-1:0] KEY_W      = 9'h01D;
    localparam logic [CODE_W-1:0] KEY_S      = 9'h01B;
    localparam logic [CODE_W-1:0] KEY_A      = 9'h01C;
    localparam logic [CODE_W-1:0] KEY_D      = 9'h023;
    localparam logic [CODE_W-1:0] KEY_SPACE  = 9'h029;
    localparam logic [CODE_W-1:0] KEY_LSHIFT = 9'h012;
    localparam logic [CODE_W-1:0] KEY_RSHIFT = 9'h059;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_HOLD
    } rpt_state_e;

    // Counter must hold the larger reload value; never narrower than 1 bit.
    function automatic int cnt_width(int dly, int per);
        int m;
        m = (dly > per) ? dly : per;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/key_action_decoder_if.sv
// Scan-code front end to game-control bundle around the action decoder.
// master drives scan events and controls, slave returns key actions.
interface key_action_decoder_if
    import key_pkg::*;
#(
    parameter int NUM_KEYS = 5
);

    logic                been_ready;
    logic [CODE_W-1:0]   last_change;
    logic [KMAP_W-1:0]   key_down;
    logic                enable;
    logic                clear;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic                any_held;

    modport master (
        output been_ready,
        output last_change,
        output key_down,
        output enable,
        output clear,
        input  held,
        input  press_pulse,
        input  release_pulse,
        input  any_held
    );

    modport slave (
        input  been_ready,
        input  last_change,
        input  key_down,
        input  enable,
        input  clear,
        output held,
        output press_pulse,
        output release_pulse,
        output any_held
    );

endinterface

// File: rtl/key_repeat_timer.sv
// Per-channel press/release tracker with typematic auto-repeat.
// Outputs are registered; held_next exposes the next held level.
module key_repeat_timer
    import key_pkg::*;
#(
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 1,
    parameter int CNT_W         = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic make,
    input  logic brk,
    input  logic clear,
    input  logic enable,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic held_next
);

    localparam logic [CNT_W-1:0] DLY_LD =
        CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] PER_LD =
        CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rpt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             expired;

    assign expired = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (make) begin
                        held_d  = 1'b1;
                        press_d = enable;
                        if (REPEAT_DELAY == 0) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = DLY_LD;
                        end
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    // A break wins over a repeat expiring in the same cycle.
                    if (brk) begin
                        state_d = ST_IDLE;
                        held_d  = 1'b0;
                        rel_d   = 1'b1;
                    end else if (expired) begin
                        state_d = ST_REPEAT;
                        press_d = enable;
                        cnt_d   = PER_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (brk) begin
                        state_d = ST_IDLE;
                        held_d  = 1'b0;
                        rel_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    held_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign held_next     = held_d;

endmodule

// File: rtl/key_action_decoder.sv
// Maps programmable scan codes to per-key held levels and press,
// release and auto-repeat pulses.
module key_action_decoder
    import key_pkg::*;
#(
    parameter int                         NUM_KEYS      = 5,
    parameter logic [NUM_KEYS*CODE_W-1:0] KEY_CODES     =
        {KEY_SPACE, KEY_W, KEY_S, KEY_A, KEY_D},
    parameter int                         REPEAT_DELAY  = 0,
    parameter int                         REPEAT_PERIOD = 1
) (
    input logic                 clk,
    input logic                 rst,
    key_action_decoder_if.slave bus
);

    localparam int CNT_W = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);

    logic                down;
    logic [NUM_KEYS-1:0] hit_v;
    logic [NUM_KEYS-1:0] make_v;
    logic [NUM_KEYS-1:0] brk_v;
    logic [NUM_KEYS-1:0] held_v;
    logic [NUM_KEYS-1:0] press_v;
    logic [NUM_KEYS-1:0] rel_v;
    logic [NUM_KEYS-1:0] held_nx_v;
    logic                any_held_q;

    // Duplicate codes simply light several channels at once.
    always_comb begin
        down   = bus.key_down[bus.last_change];
        hit_v  = '0;
        make_v = '0;
        brk_v  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            hit_v[i]  = bus.been_ready &&
                        (bus.last_change == KEY_CODES[CODE_W*i +: CODE_W]);
            make_v[i] = hit_v[i] && down;
            brk_v[i]  = hit_v[i] && !down;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_repeat_timer #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_tmr (
            .clk           (clk),
            .rst           (rst),
            .make          (make_v[i]),
            .brk           (brk_v[i]),
            .clear         (bus.clear),
            .enable        (bus.enable),
            .held          (held_v[i]),
            .press_pulse   (press_v[i]),
            .release_pulse (rel_v[i]),
            .held_next     (held_nx_v[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_held_q <= 1'b0;
        end else begin
            any_held_q <= |held_nx_v;
        end
    end

    assign bus.held          = held_v;
    assign bus.press_pulse   = press_v;
    assign bus.release_pulse = rel_v;
    assign bus.any_held      = any_held_q;

endmodule

// File: tb/tb_key_action_decoder.sv
// Scoreboard bench for key_action_decoder: DELAY=4, PERIOD=2, default codes.
// Observed word is {held, press_pulse, release_pulse, any_held}.
module tb_key_action_decoder;
    import key_pkg::*;

    localparam int NK = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_action_decoder_if #(.NUM_KEYS(NK)) bus ();

    key_action_decoder #(
        .NUM_KEYS      (NK),
        .REPEAT_DELAY  (4),
        .REPEAT_PERIOD (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] sb[$];
    logic [15:0] e;
    int n_cmp = 0;
    int n_bad = 0;

    wire [15:0] obs = {bus.held, bus.press_pulse,
                       bus.release_pulse, bus.any_held};

    function automatic logic [15:0] ev(logic [4:0] h, logic [4:0] p,
                                       logic [4:0] r);
        return {h, p, r, |h};
    endfunction

    task automatic drive(input logic br, input logic [8:0] code,
                         input logic dn);
        bus.been_ready  = br;
        bus.last_change = code;
        if (br) bus.key_down[code] = dn;
    endtask

    task automatic test_reset();
        bus.been_ready  = 1'b0;
        bus.last_change = '0;
        bus.key_down    = '0;
        bus.enable      = 1'b1;
        bus.clear       = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(ev(0, 0, 0));
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL reset_held got=%h want=%h", obs, e);
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sb.push_back(ev(0, 0, 0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_idle k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_press_repeat();
        logic [4:0] h, p, r;
        for (int k = 0; k < 12; k++) begin
            drive(k == 0 || k == 10, KEY_W, k == 0);
            h = (k < 10) ? 5'b01000 : 5'b0;
            p = (k == 0 || (k >= 4 && k < 10 && k % 2 == 0)) ? 5'b01000 : 5'b0;
            r = (k == 10) ? 5'b01000 : 5'b0;
            sb.push_back(ev(h, p, r));
            @(posedge clk);
            #1;
            bus.been_ready = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL press_repeat k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_resend();
        logic [4:0] h, p, r;
        logic mk;
        for (int k = 0; k < 13; k++) begin
            mk = (k == 0 || k == 3 || k == 6 || k == 9);
            drive(mk || k == 11, KEY_SPACE, mk);
            h = (k < 11) ? 5'b10000 : 5'b0;
            p = (k == 0 || (k >= 4 && k < 11 && k % 2 == 0)) ? 5'b10000 : 5'b0;
            r = (k == 11) ? 5'b10000 : 5'b0;
            sb.push_back(ev(h, p, r));
            @(posedge clk);
            #1;
            bus.been_ready = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL resend k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_enable_mask();
        logic [4:0] h, r;
        bus.enable = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(k == 0 || k == 6, KEY_D, k == 0);
            h = (k < 6) ? 5'b00001 : 5'b0;
            r = (k == 6) ? 5'b00001 : 5'b0;
            sb.push_back(ev(h, 5'b0, r));
            @(posedge clk);
            #1;
            bus.been_ready = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL enable_mask k=%0d got=%h want=%h", k, obs, e);
            end
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_clear();
        logic [15:0] want[6];
        want[0] = ev(5'b01000, 5'b01000, 5'b0);
        want[1] = ev(5'b01010, 5'b00010, 5'b0);
        want[2] = ev(5'b01010, 5'b0, 5'b0);
        want[3] = ev(5'b0, 5'b0, 5'b0);
        want[4] = ev(5'b0, 5'b0, 5'b0);
        want[5] = ev(5'b0, 5'b0, 5'b0);
        for (int k = 0; k < 6; k++) begin
            bus.been_ready = 1'b0;
            if (k == 0) drive(1'b1, KEY_W, 1'b1);
            if (k == 1) drive(1'b1, KEY_A, 1'b1);
            if (k == 4) drive(1'b1, KEY_A, 1'b0);
            bus.clear = (k == 3);
            sb.push_back(want[k]);
            @(posedge clk);
            #1;
            bus.been_ready = 1'b0;
            bus.clear      = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL clear k=%0d got=%h want=%h", k, obs, e);
            end
        end
        bus.key_down = '0;
    endtask

    task automatic test_ignored();
        for (int k = 0; k < 3; k++) begin
            bus.been_ready = 1'b0;
            if (k == 0) drive(1'b1, KEY_S, 1'b0);
            if (k == 1) drive(1'b1, 9'h015, 1'b1);
            sb.push_back(ev(0, 0, 0));
            @(posedge clk);
            #1;
            bus.been_ready = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL ignored k=%0d got=%h want=%h", k, obs, e);
            end
        end
        bus.key_down = '0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] want[5];
        want[0] = ev(5'b00100, 5'b00100, 5'b0);
        want[1] = ev(5'b00101, 5'b00001, 5'b0);
        want[2] = ev(5'b00001, 5'b0, 5'b00100);
        want[3] = ev(5'b0, 5'b0, 5'b00001);
        want[4] = ev(5'b0, 5'b0, 5'b0);
        for (int k = 0; k < 5; k++) begin
            bus.been_ready = 1'b0;
            if (k == 0) drive(1'b1, KEY_S, 1'b1);
            if (k == 1) drive(1'b1, KEY_D, 1'b1);
            if (k == 2) drive(1'b1, KEY_S, 1'b0);
            if (k == 3) drive(1'b1, KEY_D, 1'b0);
            sb.push_back(want[k]);
            @(posedge clk);
            #1;
            bus.been_ready = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL back_to_back k=%0d got=%h want=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] p;
        for (int k = 0; k < 6; k++) begin
            drive(k == 0, KEY_S, 1'b1);
            p = (k == 0 || k == 4) ? 5'b00100 : 5'b0;
            sb.push_back(ev(5'b00100, p, 5'b0));
            @(posedge clk);
            #1;
            bus.been_ready = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL async_pre k=%0d got=%h want=%h", k, obs, e);
            end
        end
        #2;
        rst = 1'b1;
        sb.push_back(ev(0, 0, 0));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL async_rst got=%h want=%h", obs, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(ev(0, 0, 0));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL async_post k=%0d got=%h want=%h", k, obs, e);
            end
        end
        bus.key_down = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_press_repeat();
        test_resend();
        test_enable_mask();
        test_clear();
        test_ignored();
        test_back_to_back();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_action_decoder.md
# key_action_decoder

Parametrised keyboard action decoder, the next generation of the fixed WASD/space decoder. It maps NUM_KEYS programmable PS/2 scan codes to per-key held levels and one-cycle press and release pulses. It adds typematic-style auto-repeat pulses generated in-core, a pulse-enable mask and a synchronous clear. It sits between the keyboard scan-code front end (been_ready / last_change / key_down) and game control logic (movement, fire).

## Interface
- NUM_KEYS, 5: number of key channels, 1..16.
- KEY_CODES, {9'h029, 9'h01D, 9'h01B, 9'h01C, 9'h023}: packed NUM_KEYS*9 bits; channel i code = KEY_CODES[9*i+8 : 9*i]. The default makes ch0 = D, ch1 = A, ch2 = S, ch3 = W, ch4 = space.
- REPEAT_DELAY, 0: cycles from the press pulse to the first repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 1: cycles between subsequent repeat pulses; must be ≥1.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- been_ready  in  1  one-cycle strobe: last_change is valid this cycle
- last_change  in  9  scan code of the latest make/break event; bit 8 = extended (E0) prefix
- key_down  in  512  current pressed map indexed by scan code
- enable  in  1  1 = pulses pass; 0 = press/repeat pulses forced low (tracking continues)
- clear  in  1  synchronous: drop all channels to released, no release pulses
- held  out  NUM_KEYS  registered level, 1 while the channel's key is down
- press_pulse  out  NUM_KEYS  one-cycle pulse on press and on each auto-repeat
- release_pulse  out  NUM_KEYS  one-cycle pulse on release
- any_held  out  1  OR of held, registered

## Operation
- Event for channel i: been_ready && last_change == code_i, full 9-bit compare. Make = key_down[last_change]; break = !key_down[last_change].
- Duplicate codes in KEY_CODES: every matching channel responds identically.
- Per-channel FSM states are IDLE, DELAY, REPEAT, HOLD.
  - IDLE + make: held←1, press_pulse←enable, cnt←REPEAT_DELAY-1, go to DELAY. If REPEAT_DELAY==0, go to HOLD instead.
  - DELAY: when cnt==0, press_pulse←enable, cnt←REPEAT_PERIOD-1, go to REPEAT; otherwise cnt←cnt-1.
  - REPEAT: when cnt==0, press_pulse←enable and cnt←REPEAT_PERIOD-1; otherwise cnt←cnt-1.
  - DELAY/REPEAT/HOLD + break: held←0, release_pulse←1, go to IDLE. Break takes priority over a same-cycle repeat expiry.
  - Non-IDLE + make (keyboard typematic resend): ignored. No pulse, counter not restarted.
  - IDLE + break: ignored, no pulse.
- enable low masks press_pulse only. FSM, counters, held and release_pulse all proceed normally.
- Priority: rst > clear > events. clear forces every FSM to IDLE and held←0, with all pulses 0 that cycle.
- Counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1), minimum 1. The counter never wraps; it reloads at 0.

## Timing
- Reset values: held=0, press_pulse=0, release_pulse=0, any_held=0, all FSMs IDLE, cnt=0.
- Latency: an event sampled at edge E appears on held/pulses immediately after E (1 cycle). any_held follows held with the same latency, computed from next-state.
- Pulses are exactly one cycle wide. A pulse and its held transition appear in the same cycle.
- First repeat pulse: REPEAT_DELAY cycles after the press pulse. Later repeat pulses: every REPEAT_PERIOD cycles. REPEAT_PERIOD=1 gives continuous high.
- Reset mid-hold: outputs clear immediately (async). There is no release pulse after reset deassert.
- Events for different channels need no arbitration: only one code per been_ready, so at most one event channel-group per cycle.

## Structure
- Shared package key_pkg:
  - scan-code constants: KEY_W 9'h01D, KEY_S 9'h01B, KEY_A 9'h01C, KEY_D 9'h023, KEY_SPACE 9'h029, KEY_LSHIFT 9'h012, KEY_RSHIFT 9'h059;
  - the repeat FSM state enum;
  - the code width constant 9.
- Sub-module key_repeat_timer holds the per-channel FSM and counter, with inputs make, brk, clear, enable and outputs held, press_pulse, release_pulse. It is instantiated NUM_KEYS times by generate. The top level holds only the decode/compare and any_held.

## Test plan
Bench config: NUM_KEYS=5, default codes, REPEAT_DELAY=4, REPEAT_PERIOD=2.
- Reset, then idle 10 cycles → all outputs 0.
- been_ready, last_change=0x01D, key_down[0x01D]=1 → held[3]=1 and press_pulse[3]=1 the next cycle only. Repeat pulses follow at +4, +6, +8. Break after that → release_pulse[3] 1 cycle, held[3]=0.
- Make 0x029 repeated every 3 cycles while held → only the initial press and the timer-driven repeats. Resends add no pulses.
- enable=0, press 0x023 → held[0]=1, no press_pulse. Release still gives release_pulse[0].
- Hold W and A, assert clear → held=0, no release_pulses. A later break 0x01C → no pulse.
- Break 0x01B while IDLE, and make of unmapped 0x015 → no output change. Async rst mid-repeat → outputs 0 immediately.
